// File: rtl/impl_pkg.sv
// Shared widths and types for the (A + B) * C streaming compute block.
// The result width is derived from the operand width and is not a free parameter.
package impl_pkg;

    localparam int DATA_W_DEF = 8;

    function automatic int res_w(input int dw);
        return 2 * dw + 1;
    endfunction

    localparam int RES_W_DEF = res_w(DATA_W_DEF);

    typedef logic [DATA_W_DEF-1:0] operand_t;
    typedef logic [RES_W_DEF-1:0]  result_t;

endpackage

// File: rtl/impl_in_buf.sv
// One-entry Avalon-ST sink buffer: captures one operand and holds it until cleared.
// Latency: data visible on q the cycle after valid && ready. Backpressure: ready = ~full.
// A clear always wins; the slot reopens one cycle later.
module impl_in_buf
    import impl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic [DATA_W-1:0] q,
    output logic              full,
    input  logic              clear
);

    assign ready = ~full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (valid && !full) begin
            q    <= data;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/impl_unit.sv
// Three-operand Avalon-ST sink producing R = (A + B) * C on a registered conduit.
// Latency: result one edge after the last operand lands; readys stay low until then.
// Optional coe_R_valid strobe when IMPL_RESULT_VALID_EN is defined.
module impl_unit
    import impl_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    localparam int RES_W  = res_w(DATA_W)
) (
    input  logic              csi_clk,
    input  logic              rsi_reset,
    input  logic [DATA_W-1:0] asi_in0_data,
    input  logic              asi_in0_valid,
    output logic              asi_in0_ready,
    input  logic [DATA_W-1:0] asi_in1_data,
    input  logic              asi_in1_valid,
    output logic              asi_in1_ready,
    input  logic [DATA_W-1:0] asi_in2_data,
    input  logic              asi_in2_valid,
    output logic              asi_in2_ready,
    output logic [RES_W-1:0]  coe_R
`ifdef IMPL_RESULT_VALID_EN
    ,
    output logic              coe_R_valid
`endif
);

    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic              a_full, b_full, c_full;
    logic              fire;
    logic [RES_W-1:0]  sum_ext, prod;

    assign fire = a_full & b_full & c_full;

    impl_in_buf #(.DATA_W(DATA_W)) u_buf_a (
        .clk(csi_clk), .reset(rsi_reset),
        .data(asi_in0_data), .valid(asi_in0_valid), .ready(asi_in0_ready),
        .q(a_q), .full(a_full), .clear(fire)
    );

    impl_in_buf #(.DATA_W(DATA_W)) u_buf_b (
        .clk(csi_clk), .reset(rsi_reset),
        .data(asi_in1_data), .valid(asi_in1_valid), .ready(asi_in1_ready),
        .q(b_q), .full(b_full), .clear(fire)
    );

    impl_in_buf #(.DATA_W(DATA_W)) u_buf_c (
        .clk(csi_clk), .reset(rsi_reset),
        .data(asi_in2_data), .valid(asi_in2_valid), .ready(asi_in2_ready),
        .q(c_q), .full(c_full), .clear(fire)
    );

    // Widen before adding so the carry of A + B survives into the multiply.
    assign sum_ext = RES_W'(a_q) + RES_W'(b_q);
    assign prod    = sum_ext * RES_W'(c_q);

    always_ff @(posedge csi_clk or negedge rsi_reset) begin
        if (!rsi_reset) begin
            coe_R <= '0;
        end else if (fire) begin
            coe_R <= prod;
        end
    end

`ifdef IMPL_RESULT_VALID_EN
    always_ff @(posedge csi_clk or negedge rsi_reset) begin
        if (!rsi_reset) begin
            coe_R_valid <= 1'b0;
        end else begin
            coe_R_valid <= fire;
        end
    end
`endif

endmodule

// File: tb/tb_impl_unit.sv
// Scoreboard bench for impl_unit: expected results queued at stimulus time, popped on each compute.
module tb_impl_unit;

    logic        csi_clk = 1'b0;
    logic        rsi_reset;
    logic [7:0]  a_dat, b_dat, c_dat;
    logic        a_vld, b_vld, c_vld;
    logic        a_rdy, b_rdy, c_rdy;
    logic [16:0] coe_R;
`ifdef IMPL_RESULT_VALID_EN
    logic        coe_R_valid;
`endif

    int unsigned exp_q[$];
    int unsigned exp_val;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        prev_full = 1'b0;

    always #5 csi_clk = ~csi_clk;

    impl_unit dut (
        .csi_clk       (csi_clk),
        .rsi_reset     (rsi_reset),
        .asi_in0_data  (a_dat),
        .asi_in0_valid (a_vld),
        .asi_in0_ready (a_rdy),
        .asi_in1_data  (b_dat),
        .asi_in1_valid (b_vld),
        .asi_in1_ready (b_rdy),
        .asi_in2_data  (c_dat),
        .asi_in2_valid (c_vld),
        .asi_in2_ready (c_rdy),
        .coe_R         (coe_R)
`ifdef IMPL_RESULT_VALID_EN
        ,
        .coe_R_valid   (coe_R_valid)
`endif
    );

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge csi_clk);
        @(negedge csi_clk);
    endtask

    task automatic drive_set(input int unsigned a, input int unsigned b, input int unsigned c);
        a_dat = 8'(a); b_dat = 8'(b); c_dat = 8'(c);
        a_vld = 1'b1;  b_vld = 1'b1;  c_vld = 1'b1;
        exp_q.push_back((a + b) * c);
    endtask

    task automatic idle();
        a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    endtask

    // All three buffers full at one negedge means a compute on the next posedge.
    always @(negedge csi_clk) begin
        if (!rsi_reset) begin
            prev_full = 1'b0;
        end else begin
            if (prev_full) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", coe_R, 0);
                end else begin
                    exp_val = exp_q.pop_front();
                    check("sb_result", coe_R, exp_val);
                end
            end
`ifdef IMPL_RESULT_VALID_EN
            if (coe_R_valid || prev_full)
                check("r_valid_pulse", coe_R_valid, prev_full);
`endif
            prev_full = !(a_rdy || b_rdy || c_rdy);
        end
    end

    initial begin
        rsi_reset = 1'b0;
        a_dat = '0; b_dat = '0; c_dat = '0;
        idle();
        repeat (2) @(negedge csi_clk);
        check("reset_R", coe_R, 0);
        check("reset_rdy", {a_rdy, b_rdy, c_rdy}, 3'b111);
        rsi_reset = 1'b1;
        cycle();

        // Simultaneous arrival 3,4,5
        drive_set(3, 4, 5);
        cycle();
        idle();
        check("t1_rdy_low", {a_rdy, b_rdy, c_rdy}, 3'b000);
        check("t1_R_hold", coe_R, 0);
        cycle();
        check("t1_R", coe_R, 35);
        check("t1_rdy_back", {a_rdy, b_rdy, c_rdy}, 3'b111);
        cycle();

        // Maximum operands, no truncation
        drive_set(255, 255, 255);
        cycle();
        idle();
        cycle();
        check("t2_max", coe_R, 17'h1FC02);
        cycle();

        // Staggered: A at edge 0, B at edge 3, C at edge 5, compute at edge 6
        a_dat = 8'd10; a_vld = 1'b1;
        cycle();
        a_vld = 1'b0;
        check("t3_a_rdy_c1", a_rdy, 0);
        check("t3_b_rdy_c1", b_rdy, 1);
        cycle();
        cycle();
        b_dat = 8'd20; b_vld = 1'b1;
        cycle();
        b_vld = 1'b0;
        check("t3_rdy_c4", {a_rdy, b_rdy, c_rdy}, 3'b001);
        check("t3_R_hold_c4", coe_R, 130050);
        cycle();
        c_dat = 8'd7; c_vld = 1'b1;
        exp_q.push_back(210);
        cycle();
        c_vld = 1'b0;
        check("t3_rdy_c6", {a_rdy, b_rdy, c_rdy}, 3'b000);
        check("t3_R_hold_c6", coe_R, 130050);
        cycle();
        check("t3_R", coe_R, 210);
        check("t3_rdy_after", {a_rdy, b_rdy, c_rdy}, 3'b111);
        cycle();

        // Valid held while ready low: A=9 must wait until after the compute
        a_dat = 8'd2; a_vld = 1'b1;
        cycle();
        a_dat = 8'd9;
        b_dat = 8'd1; b_vld = 1'b1;
        c_dat = 8'd1; c_vld = 1'b1;
        exp_q.push_back(3);
        cycle();
        b_vld = 1'b0; c_vld = 1'b0;
        cycle();
        check("t4_R_old_a", coe_R, 3);
        check("t4_a_rdy_reopen", a_rdy, 1);
        cycle();
        a_vld = 1'b0;
        check("t4_a_captured", a_rdy, 0);
        b_dat = 8'd1; b_vld = 1'b1;
        c_dat = 8'd2; c_vld = 1'b1;
        exp_q.push_back(20);
        cycle();
        idle();
        cycle();
        check("t4_R_new_a", coe_R, 20);
        cycle();

        // Reset mid-collection discards A and B
        a_dat = 8'd50; a_vld = 1'b1;
        b_dat = 8'd60; b_vld = 1'b1;
        cycle();
        idle();
        check("t5_partial_rdy", {a_rdy, b_rdy, c_rdy}, 3'b001);
        #2 rsi_reset = 1'b0;
        #1;
        check("t5_async_R", coe_R, 0);
        check("t5_async_rdy", {a_rdy, b_rdy, c_rdy}, 3'b111);
        @(negedge csi_clk);
        rsi_reset = 1'b1;
        cycle();
        drive_set(1, 1, 2);
        cycle();
        idle();
        cycle();
        check("t5_R_fresh", coe_R, 4);
        cycle();

        // Back-to-back with continuous valid: results two cycles apart
        drive_set(2, 3, 4);
        cycle();
        a_dat = 8'd0; b_dat = 8'd7; c_dat = 8'd9;
        exp_q.push_back(63);
        cycle();
        check("t6_first", coe_R, 20);
        cycle();
        idle();
        check("t6_first_hold", coe_R, 20);
        cycle();
        check("t6_second", coe_R, 63);
        cycle();

        // Random simultaneous sets
        for (int i = 0; i < 8; i++) begin
            drive_set($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            cycle();
            idle();
            cycle();
        end
        repeat (3) cycle();

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
